// File: rtl/msdf_otf_collector_pkg.sv
// Shared constants for the MSDF on-the-fly collector: digit encodings, default width, FSM states.
package msdf_otf_collector_pkg;

  localparam int unsigned OUT_W_DEFAULT = 32;

  localparam logic [1:0] DIGIT_POS = 2'b01;
  localparam logic [1:0] DIGIT_NEG = 2'b10;

  typedef enum logic {
    S_ACC,
    S_OUT
  } state_t;

endpackage

// File: rtl/msdf_otf_step.sv
// One on-the-fly conversion step: next Q/QM from current Q, QM and a signed digit.
module msdf_otf_step
  import msdf_otf_collector_pkg::*;
#(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  input  logic [1:0]   digit,
  output logic [W-1:0] q_next,
  output logic [W-1:0] qm_next
);

  always_comb begin
    q_next  = {q[W-2:0], 1'b0};
    qm_next = {qm[W-2:0], 1'b1};
    case (digit)
      DIGIT_POS: begin
        q_next  = {q[W-2:0], 1'b1};
        qm_next = {q[W-2:0], 1'b0};
      end
      DIGIT_NEG: begin
        q_next  = {qm[W-2:0], 1'b1};
        qm_next = {qm[W-2:0], 1'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/msdf_otf_collector.sv
// Collects MSB-first signed digits into a left-aligned two's complement result.
// Define MSDF_OTF_STATUS_EN to add statusOut = {trunc, digit count saturating at 127}.
module msdf_otf_collector
  import msdf_otf_collector_pkg::*;
#(
  parameter int unsigned OUT_W = OUT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       dataInArray_0,
  input  logic             pValidArray_0,
  output logic             readyArray_0,
  output logic [OUT_W:0]   dataOutArray_0,
  output logic             validArray_0,
  input  logic             nReadyArray_0
`ifdef MSDF_OTF_STATUS_EN
  ,
  output logic [7:0]       statusOut
`endif
);

  localparam int unsigned CW = $clog2(OUT_W + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(OUT_W);

  state_t          state;
  logic [OUT_W:0]  q, qm, q_next, qm_next, q_final, result;
  logic [CW-1:0]   count, k;
  logic            in_range, take, give;

`ifdef MSDF_OTF_STATUS_EN
  logic            trunc;
  logic [6:0]      status_cnt, status_next;
  assign status_next = (status_cnt == 7'h7f) ? status_cnt : status_cnt + 7'd1;
`endif

  assign readyArray_0 = (state == S_ACC);
  assign validArray_0 = (state == S_OUT);
  assign take = pValidArray_0 & readyArray_0;
  assign give = validArray_0 & nReadyArray_0;

  msdf_otf_step #(.W(OUT_W + 1)) u_step (
    .q       (q),
    .qm      (qm),
    .digit   (dataInArray_0[1:0]),
    .q_next  (q_next),
    .qm_next (qm_next)
  );

  // The last digit is folded in combinationally so the result is ready one cycle after it arrives.
  always_comb begin
    in_range = (count < CNT_MAX);
    k        = in_range ? count + 1'b1 : CNT_MAX;
    q_final  = in_range ? q_next : q;
    result   = q_final << (CNT_MAX - k);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_ACC;
      q              <= '0;
      qm             <= '1;
      count          <= '0;
      dataOutArray_0 <= '0;
`ifdef MSDF_OTF_STATUS_EN
      trunc          <= 1'b0;
      status_cnt     <= '0;
      statusOut      <= '0;
`endif
    end else begin
      case (state)
        S_ACC: begin
          if (take) begin
            if (in_range) begin
              q     <= q_next;
              qm    <= qm_next;
              count <= count + 1'b1;
            end
`ifdef MSDF_OTF_STATUS_EN
            else begin
              trunc <= 1'b1;
            end
            status_cnt <= status_next;
`endif
            if (dataInArray_0[2]) begin
              dataOutArray_0 <= result;
              state          <= S_OUT;
`ifdef MSDF_OTF_STATUS_EN
              statusOut      <= {trunc | ~in_range, status_next};
`endif
            end
          end
        end
        S_OUT: begin
          if (give) begin
            state <= S_ACC;
            q     <= '0;
            qm    <= '1;
            count <= '0;
`ifdef MSDF_OTF_STATUS_EN
            trunc      <= 1'b0;
            status_cnt <= '0;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msdf_otf_collector.sv
// Self-checking bench for msdf_otf_collector (OUT_W=32); honours MSDF_OTF_STATUS_EN.
module tb_msdf_otf_collector;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   din = '0;
  logic         pvalid = 1'b0;
  logic         nready = 1'b1;
  logic         ready, valid;
  logic [W:0]   dout;
`ifdef MSDF_OTF_STATUS_EN
  logic [7:0]   status;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msdf_otf_collector #(.OUT_W(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .dataInArray_0  (din),
    .pValidArray_0  (pvalid),
    .readyArray_0   (ready),
    .dataOutArray_0 (dout),
    .validArray_0   (valid),
    .nReadyArray_0  (nready)
`ifdef MSDF_OTF_STATUS_EN
    ,
    .statusOut      (status)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: value of the digit string as a fraction scaled by 2^W.
  int          mdig[$];
  bit          mhold = 1'b0;
  bit          armed = 1'b0;
  logic [W:0]  mdata;
  logic [7:0]  mstat;
  logic [W:0]  got[$];

  function automatic int dval(input logic [1:0] d);
    if (d == 2'b01) return 1;
    if (d == 2'b10) return -1;
    return 0;
  endfunction

  function automatic logic [W:0] ref_value();
    longint acc = 0;
    for (int i = 0; i < mdig.size() && i < W; i++)
      acc += longint'(mdig[i]) <<< (W - 1 - i);
    return acc[W:0];
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      chk("valid", {63'd0, valid}, {63'd0, mhold});
      chk("ready", {63'd0, ready}, {63'd0, !mhold});
      if (mhold) begin
        chk("data", {31'd0, dout}, {31'd0, mdata});
`ifdef MSDF_OTF_STATUS_EN
        chk("status", {56'd0, status}, {56'd0, mstat});
`endif
      end
    end
    if (rst) begin
      mdig.delete();
      mhold = 1'b0;
      armed = 1'b1;
    end else if (armed) begin
      if (!mhold && pvalid) begin
        mdig.push_back(dval(din[1:0]));
        if (din[2]) begin
          mdata = ref_value();
          mstat = {mdig.size() > W, (mdig.size() > 127) ? 7'd127 : 7'(mdig.size())};
          mhold = 1'b1;
          mdig.delete();
        end
      end else if (mhold && nready) begin
        got.push_back(dout);
        mhold = 1'b0;
      end
    end
  end

  logic [1:0] seq[$];

  task automatic send(input logic [1:0] d, input bit last);
    bit took = 1'b0;
    int b = 0;
    din    = {last, d};
    pvalid = 1'b1;
    do begin
      @(negedge clk);
      took = ready;
      @(posedge clk);
      #1;
      b++;
    end while (!took && b < 100);
    if (!took) chk("send_timeout", 64'd0, 64'd1);
    pvalid = 1'b0;
    din    = '0;
  endtask

  task automatic send_seq(input int gap);
    for (int i = 0; i < seq.size(); i++) begin
      send(seq[i], i == seq.size() - 1);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic expect_result(input string name, input logic [W:0] exp);
    int b = 0;
    while (got.size() == 0 && b < 200) begin
      @(posedge clk);
      #1;
      b++;
    end
    if (got.size() == 0) chk({name, "_timeout"}, 64'd0, 64'd1);
    else chk(name, {31'd0, got.pop_front()}, {31'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_data", {31'd0, dout}, 64'd0);
    chk("reset_ready", {63'd0, ready}, 64'd1);

    seq = '{2'b01, 2'b00, 2'b10};
    send_seq(0);
    expect_result("three_eighths", 33'h0_6000_0000);

    seq = '{2'b10};
    send_seq(0);
    expect_result("minus_half", 33'h1_8000_0000);

    seq.delete();
    repeat (32) seq.push_back(2'b01);
    send_seq(0);
    expect_result("all_ones_32", 33'h0_FFFF_FFFF);

    seq.delete();
    seq.push_back(2'b10);
    repeat (39) seq.push_back(2'b01);
    send_seq(0);
`ifdef MSDF_OTF_STATUS_EN
    chk("status_a8", {56'd0, status}, 64'hA8);
`endif
    expect_result("trunc_40", 33'h1_FFFF_FFFF);

    seq = '{2'b11, 2'b01, 2'b10};
    send_seq(2);
    expect_result("one_eighth_gaps", 33'h0_2000_0000);

    nready = 1'b0;
    seq = '{2'b01, 2'b01};
    send_seq(0);
    seq = '{2'b00, 2'b01};
    fork
      send_seq(0);
      begin
        repeat (10) @(posedge clk);
        #1;
        chk("stall_ready", {63'd0, ready}, 64'd0);
        chk("stall_valid", {63'd0, valid}, 64'd1);
        chk("stall_data", {31'd0, dout}, {31'd0, 33'h0_C000_0000});
        nready = 1'b1;
      end
    join
    expect_result("stalled_word", 33'h0_C000_0000);
    expect_result("after_stall", 33'h0_4000_0000);

    for (int i = 0; i < 5; i++) send(2'b10, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    send(2'b01, 1'b1);
    expect_result("after_midword_rst", 33'h0_8000_0000);

    nready = 1'b0;
    send(2'b01, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_hold_data", {31'd0, dout}, 64'd0);
    chk("rst_hold_valid", {63'd0, valid}, 64'd0);
    chk("rst_hold_no_result", 64'(got.size()), 64'd0);
    nready = 1'b1;
    seq = '{2'b00, 2'b00, 2'b10};
    send_seq(1);
    expect_result("minus_eighth", 33'h1_E000_0000);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
